pc_unit: RTL and testbench
==========================

PC_UNIT -- requirements
Module: pc_unit

Interface
REQ-001 SHALL have parameter RESET_VECTOR, default 16'hFFFC, the address of the reset-vector low byte (high byte at RESET_VECTOR+1).
REQ-002 SHALL have port clk  input  1  the single system clock; all state updates on its rising edge.
REQ-003 SHALL have port reset_n  input  1  reset, synchronous and active-low.
REQ-004 SHALL have port pc_op  input  pc_op_t (3)  the PC operation for this cycle.
REQ-005 SHALL have port data_in  input  data_t (8)  the memory read data bus.
REQ-006 SHALL have port jmp_addr  input  addr_t (16)  the absolute target for PC_JMP.
REQ-007 SHALL have port pc_out  output  addr_t (16)  the current PC, which feeds the address mux PC input.
REQ-008 SHALL have port ready  output  1  high once the reset vector is loaded and pc_op is being honoured.
REQ-009 SHALL have port page_cross  output  1  a one-cycle flag that a PC_REL changed pc_out[15:8].

Function
REQ-010 SHALL assume memory read latency of one cycle: an address on pc_out in cycle N gives data_in valid in cycle N+1.
REQ-011 SHALL implement FSM states VEC_LO, VEC_HI, VEC_LOAD and RUN.
REQ-012 SHALL, in VEC_LO, drive pc_out=RESET_VECTOR, then go to VEC_HI.
REQ-013 SHALL, in VEC_HI, drive pc_out=RESET_VECTOR+1, latch data_in as the vector low byte, then go to VEC_LOAD.
REQ-014 SHALL, in VEC_LOAD, hold pc_out=RESET_VECTOR+1, latch data_in as the high byte, load PC={hi,lo} at the clock edge, then go to RUN.
REQ-015 SHALL assert ready only in RUN, so the first cycle with ready=1 shows pc_out equal to the loaded vector.
REQ-016 SHALL ignore pc_op and jmp_addr while ready=0.
REQ-017 SHALL, in RUN, apply at each clock edge: PC_HOLD → PC unchanged.
REQ-018 SHALL, in RUN, apply PC_INC → PC+1, modulo 2^16 (16'hFFFF wraps to 16'h0000, no flag).
REQ-019 SHALL, in RUN, apply PC_LDL → PC[7:0]=data_in, with PC[15:8] unchanged.
REQ-020 SHALL, in RUN, apply PC_LDH → PC[15:8]=data_in, with PC[7:0] unchanged.
REQ-021 SHALL, in RUN, apply PC_JMP → PC=jmp_addr.
REQ-022 SHALL, in RUN, apply PC_REL → PC = PC + sign-extended data_in, modulo 2^16, completed in one cycle.
REQ-023 SHALL treat any unencoded pc_op value as PC_HOLD.
REQ-024 SHALL register page_cross: it is 1 in the cycle after a PC_REL whose result high byte differs from the old high byte, otherwise 0.
REQ-025 SHALL flag a PC_REL wrap across 16'hFFFF/16'h0000 as page_cross=1.
REQ-026 SHALL have pc_out register-driven, with no combinational path from pc_op, data_in or jmp_addr.
REQ-027 SHALL allow back-to-back operations every cycle with no stall.

Reset
REQ-028 SHALL, while reset_n=0 at a clock edge, set state=VEC_LO, pc_out=RESET_VECTOR, ready=0, page_cross=0, and clear the latched vector bytes.
REQ-029 SHALL, on reset asserted mid-fetch or in RUN, abandon the operation and restart the fetch from VEC_LO after reset_n returns to 1.
REQ-030 SHALL, on reset_n held low for multiple cycles, hold all outputs at their reset values.

Structure
REQ-031 SHALL take addr_t, data_t and a new enum pc_op_t {PC_HOLD, PC_INC, PC_LDL, PC_LDH, PC_REL, PC_JMP} from common_types; RESET_VECTOR remains a module parameter.
REQ-032 SHALL be a single module with no sub-module; the next-PC adder is inline combinational logic.

Verification
REQ-033 SHALL cover: reset, memory model returns 8'h00@FFFC and 8'hC0@FFFD → pc_out sequence FFFC, FFFD, FFFD, then C000 with ready=1 on the 4th cycle after reset release.
REQ-034 SHALL cover: at PC=C000, three PC_INC then PC_HOLD → C001, C002, C003, C003.
REQ-035 SHALL cover: PC=C0F0, PC_REL with data_in 8'h20 → C110 and page_cross=1; then PC=C110, PC_REL with data_in 8'hFE → C10E and page_cross=0.
REQ-036 SHALL cover: PC=FFFF, PC_INC → 0000 with page_cross=0; PC=FFF0, PC_REL with data_in 8'h20 → 0010 with page_cross=1.
REQ-037 SHALL cover: PC_LDL with data_in 8'h34 then PC_LDH with data_in 8'h12 → 1234; PC_JMP with jmp_addr 16'hABCD → ABCD.
REQ-038 SHALL cover: reset_n pulsed low during VEC_HI with pc_op=PC_JMP driven throughout → full fetch restarts at FFFC and ready stays 0 until VEC_LOAD completes.

Source files
------------

// File: rtl/common_types.sv
// Shared address/data widths and the PC operation encoding used by the CPU front end.
package common_types;

    typedef logic [15:0] addr_t;
    typedef logic [7:0]  data_t;

    // Codes 3'd6 and 3'd7 are left unencoded and behave as PC_HOLD.
    typedef enum logic [2:0] {
        PC_HOLD = 3'd0,
        PC_INC  = 3'd1,
        PC_LDL  = 3'd2,
        PC_LDH  = 3'd3,
        PC_REL  = 3'd4,
        PC_JMP  = 3'd5
    } pc_op_t;

endpackage

// File: rtl/pc_unit.sv
// Program counter: fetches the reset vector, then applies one pc_op per cycle.
// Latency: every op lands at the next edge; pc_out is always a flop, never a bypass.
// No backpressure: ops are accepted every cycle once ready is high, ignored before that.
module pc_unit
    import common_types::*;
#(
    parameter addr_t RESET_VECTOR = 16'hFFFC
) (
    input  logic   clk,
    input  logic   reset_n,
    input  pc_op_t pc_op,
    input  data_t  data_in,
    input  addr_t  jmp_addr,
    output addr_t  pc_out,
    output logic   ready,
    output logic   page_cross
);

    localparam logic [1:0] VEC_LO   = 2'd0;
    localparam logic [1:0] VEC_HI   = 2'd1;
    localparam logic [1:0] VEC_LOAD = 2'd2;
    localparam logic [1:0] RUN      = 2'd3;

    logic [1:0] state_q, state_d;
    addr_t      pc_q, pc_d;
    data_t      vec_lo_q, vec_lo_d;
    logic       page_cross_q, page_cross_d;
    addr_t      rel_sum;

    assign rel_sum = pc_q + {{8{data_in[7]}}, data_in};

    always_comb begin
        state_d      = state_q;
        pc_d         = pc_q;
        vec_lo_d     = vec_lo_q;
        page_cross_d = 1'b0;
        case (state_q)
            VEC_LO: begin
                pc_d    = RESET_VECTOR + 16'd1;
                state_d = VEC_HI;
            end
            // data_in now carries the byte addressed during VEC_LO.
            VEC_HI: begin
                vec_lo_d = data_in;
                state_d  = VEC_LOAD;
            end
            VEC_LOAD: begin
                pc_d    = {data_in, vec_lo_q};
                state_d = RUN;
            end
            RUN: begin
                case (pc_op)
                    PC_INC: pc_d = pc_q + 16'd1;
                    PC_LDL: pc_d = {pc_q[15:8], data_in};
                    PC_LDH: pc_d = {data_in, pc_q[7:0]};
                    PC_JMP: pc_d = jmp_addr;
                    PC_REL: begin
                        pc_d         = rel_sum;
                        page_cross_d = (rel_sum[15:8] != pc_q[15:8]);
                    end
                    default: pc_d = pc_q;
                endcase
            end
            default: begin
                state_d = VEC_LO;
                pc_d    = RESET_VECTOR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q      <= VEC_LO;
            pc_q         <= RESET_VECTOR;
            vec_lo_q     <= '0;
            page_cross_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            pc_q         <= pc_d;
            vec_lo_q     <= vec_lo_d;
            page_cross_q <= page_cross_d;
        end
    end

    assign pc_out     = pc_q;
    assign ready      = (state_q == RUN);
    assign page_cross = page_cross_q;

endmodule

// File: tb/tb_pc_unit.sv
// Scoreboard bench for pc_unit: directed ops push expected outputs, a negedge monitor pops and compares.
module tb_pc_unit;
    import common_types::*;

    typedef struct packed {
        addr_t pc;
        logic  rdy;
        logic  pcx;
    } exp_t;

    logic   clk = 1'b0;
    logic   reset_n;
    pc_op_t pc_op;
    data_t  data_in;
    addr_t  jmp_addr;
    addr_t  pc_out;
    logic   ready;
    logic   page_cross;

    logic   use_mem;
    data_t  data_drv;
    data_t  mem_rd_q;

    exp_t   exp_q[$];
    int     checks = 0;
    int     errors = 0;
    int     step_no = 0;

    always #5 clk = ~clk;

    pc_unit #(.RESET_VECTOR(16'hFFFC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .pc_op      (pc_op),
        .data_in    (data_in),
        .jmp_addr   (jmp_addr),
        .pc_out     (pc_out),
        .ready      (ready),
        .page_cross (page_cross)
    );

    // One-cycle-latency memory holding only the reset vector C000.
    function automatic data_t mem_read(input addr_t a);
        case (a)
            16'hFFFC: return 8'h00;
            16'hFFFD: return 8'hC0;
            default:  return 8'hEE;
        endcase
    endfunction

    always @(posedge clk) mem_rd_q <= mem_read(pc_out);

    assign data_in = use_mem ? mem_rd_q : data_drv;

    // Monitor: compares whatever the DUT is presenting against the oldest expectation.
    always @(negedge clk) begin
        if (exp_q.size() > 0) begin
            exp_t e;
            e = exp_q.pop_front();
            checks++;
            if (pc_out !== e.pc || ready !== e.rdy || page_cross !== e.pcx) begin
                errors++;
                $display("FAIL step%0d: got pc=%h ready=%b page_cross=%b, expected pc=%h ready=%b page_cross=%b",
                         step_no, pc_out, ready, page_cross, e.pc, e.rdy, e.pcx);
            end
        end
    end

    // Drive inputs for the next edge, then queue the outputs that edge must produce.
    task automatic cyc(input logic rstn, input pc_op_t op, input data_t d, input addr_t j,
                       input addr_t epc, input logic erdy, input logic epcx);
        exp_t e;
        reset_n  = rstn;
        pc_op    = op;
        data_drv = d;
        jmp_addr = j;
        @(posedge clk);
        #1;
        step_no++;
        e.pc  = epc;
        e.rdy = erdy;
        e.pcx = epcx;
        exp_q.push_back(e);
    endtask

    initial begin
        use_mem  = 1'b1;
        reset_n  = 1'b0;
        pc_op    = PC_JMP;
        data_drv = 8'h00;
        jmp_addr = 16'hABCD;

        // Reset held for several edges with a jump request pending.
        cyc(1'b0, PC_JMP, 8'h00, 16'hABCD, 16'hFFFC, 1'b0, 1'b0);
        cyc(1'b0, PC_JMP, 8'h00, 16'hABCD, 16'hFFFC, 1'b0, 1'b0);
        cyc(1'b0, PC_JMP, 8'h00, 16'hABCD, 16'hFFFC, 1'b0, 1'b0);
        // Vector fetch: FFFD, FFFD, then C000 with ready.
        cyc(1'b1, PC_JMP, 8'h00, 16'hABCD, 16'hFFFD, 1'b0, 1'b0);
        cyc(1'b1, PC_JMP, 8'h00, 16'hABCD, 16'hFFFD, 1'b0, 1'b0);
        cyc(1'b1, PC_HOLD, 8'h00, 16'h0000, 16'hC000, 1'b1, 1'b0);
        use_mem = 1'b0;

        cyc(1'b1, PC_INC,  8'h00, 16'h0000, 16'hC001, 1'b1, 1'b0);
        cyc(1'b1, PC_INC,  8'h00, 16'h0000, 16'hC002, 1'b1, 1'b0);
        cyc(1'b1, PC_INC,  8'h00, 16'h0000, 16'hC003, 1'b1, 1'b0);
        cyc(1'b1, PC_HOLD, 8'h00, 16'h0000, 16'hC003, 1'b1, 1'b0);
        cyc(1'b1, pc_op_t'(3'd7), 8'h55, 16'h1111, 16'hC003, 1'b1, 1'b0);
        cyc(1'b1, pc_op_t'(3'd6), 8'h55, 16'h1111, 16'hC003, 1'b1, 1'b0);

        // Relative branches across and within a page.
        cyc(1'b1, PC_JMP, 8'h00, 16'hC0F0, 16'hC0F0, 1'b1, 1'b0);
        cyc(1'b1, PC_REL, 8'h20, 16'h0000, 16'hC110, 1'b1, 1'b1);
        cyc(1'b1, PC_REL, 8'hFE, 16'h0000, 16'hC10E, 1'b1, 1'b0);
        cyc(1'b1, PC_REL, 8'h80, 16'h0000, 16'hC08E, 1'b1, 1'b1);

        // Wrap at the top of the address space.
        cyc(1'b1, PC_JMP, 8'h00, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);
        cyc(1'b1, PC_INC, 8'h00, 16'h0000, 16'h0000, 1'b1, 1'b0);
        cyc(1'b1, PC_JMP, 8'h00, 16'hFFF0, 16'hFFF0, 1'b1, 1'b0);
        cyc(1'b1, PC_REL, 8'h20, 16'h0000, 16'h0010, 1'b1, 1'b1);
        cyc(1'b1, PC_HOLD, 8'h00, 16'h0000, 16'h0010, 1'b1, 1'b0);

        // Byte loads and absolute jump.
        cyc(1'b1, PC_LDL, 8'h34, 16'h0000, 16'h0034, 1'b1, 1'b0);
        cyc(1'b1, PC_LDH, 8'h12, 16'h0000, 16'h1234, 1'b1, 1'b0);
        cyc(1'b1, PC_JMP, 8'h00, 16'hABCD, 16'hABCD, 1'b1, 1'b0);
        cyc(1'b1, PC_REL, 8'h40, 16'h0000, 16'hAC0D, 1'b1, 1'b1);

        // Reset from RUN clears page_cross, then is pulsed again during VEC_HI.
        use_mem = 1'b1;
        cyc(1'b0, PC_JMP, 8'h00, 16'hABCD, 16'hFFFC, 1'b0, 1'b0);
        cyc(1'b1, PC_JMP, 8'h00, 16'hABCD, 16'hFFFD, 1'b0, 1'b0);
        cyc(1'b0, PC_JMP, 8'h00, 16'hABCD, 16'hFFFC, 1'b0, 1'b0);
        cyc(1'b1, PC_JMP, 8'h00, 16'hABCD, 16'hFFFD, 1'b0, 1'b0);
        cyc(1'b1, PC_JMP, 8'h00, 16'hABCD, 16'hFFFD, 1'b0, 1'b0);
        cyc(1'b1, PC_JMP, 8'h00, 16'hABCD, 16'hC000, 1'b1, 1'b0);
        use_mem = 1'b0;
        cyc(1'b1, PC_INC, 8'h00, 16'h0000, 16'hC001, 1'b1, 1'b0);

        for (int i = 0; i < 20 && exp_q.size() > 0; i++) @(posedge clk);
        if (exp_q.size() > 0) begin
            errors++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
